// File: rtl/t5_dmem_pkg.sv
// Shared definitions for the t5 data-memory responder: widths and FSM state encodings.
package t5_dmem_pkg;

   localparam int unsigned T5_XLEN  = 32;
   localparam int unsigned LANES    = 4;
   localparam int unsigned LANE_W   = 8;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned WAIT_MAX = 15;

   typedef enum logic [1:0] {
      T5_DM_IDLE = 2'd0,
      T5_DM_WAIT = 2'd1,
      T5_DM_ACK  = 2'd2
   } dm_state_t;

endpackage : t5_dmem_pkg

// File: rtl/t5_dmem_dram.sv
// Word RAM with per-byte write enables and a registered, resettable read port.
module t5_dmem_dram
   import t5_dmem_pkg::*;
#(
   parameter int unsigned XLEN = T5_XLEN,
   parameter int unsigned AW   = 10
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [LANES-1:0] i_we,
   input  logic [AW-1:0]    i_addr,
   input  logic [XLEN-1:0]  i_wdata,
   input  logic             i_re,
   input  logic             i_rd_zero,
   output logic [XLEN-1:0]  o_rdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [XLEN-1:0] r_mem [DEPTH];
   logic [XLEN-1:0] r_rdata;

   // Byte-lane writes; the array itself is never reset.
   always_ff @(posedge i_clk) begin
      for (int n = 0; n < int'(LANES); n++) begin
         if (i_we[n]) begin
            r_mem[i_addr][n*LANE_W +: LANE_W] <= i_wdata[n*LANE_W +: LANE_W];
         end
      end
   end

   // Read register: cleared by reset, forced to zero for out-of-region reads, else holds.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= i_rd_zero ? '0 : r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule : t5_dmem_dram

// File: rtl/t5_dmem.sv
// Data-memory responder on the dwb_* bus: decode, wait-state FSM, single ack per strobe.
module t5_dmem
   import t5_dmem_pkg::*;
#(
   parameter int unsigned     XLEN = T5_XLEN,
   parameter int unsigned     AW   = 10,
   parameter int unsigned     WAIT = 1,
   parameter logic [XLEN-1:0] BASE = '0
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             dwb_stb,
   input  logic             dwb_wre,
   input  logic [LANES-1:0] dwb_sel,
   input  logic [XLEN-3:0]  dwb_adr,
   input  logic [XLEN-1:0]  dwb_dto,
   output logic [XLEN-1:0]  dwb_dti,
   output logic             dwb_ack
);

   if (WAIT > WAIT_MAX) begin : g_bad_wait
      $error("t5_dmem: WAIT must be in 0..15");
   end
   if (XLEN != LANES * LANE_W) begin : g_bad_xlen
      $error("t5_dmem: XLEN must match the byte-lane count");
   end

   dm_state_t        r_state;
   dm_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_ack;
   logic             w_latch;
   logic             w_enter_ack;
   logic             w_commit;

   logic             r_wre;
   logic [LANES-1:0] r_sel;
   logic [XLEN-3:0]  r_adr;
   logic [XLEN-1:0]  r_dto;

   logic             w_cur_wre;
   logic [LANES-1:0] w_cur_sel;
   logic [XLEN-3:0]  w_cur_adr;
   logic [XLEN-1:0]  w_cur_dto;
   logic             w_hit;
   logic [LANES-1:0] w_we;
   logic             w_re;

   // State, counter and ack registers with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state <= T5_DM_IDLE;
         r_cnt   <= '0;
         r_ack   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ack   <= w_enter_ack;
      end
   end

   // Next-state and wait-counter logic; bus changes are only looked at in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_enter_ack = 1'b0;
      case (r_state)
         T5_DM_IDLE: begin
            if (dwb_stb) begin
               w_latch = 1'b1;
               if (WAIT == 0) begin
                  w_state_nxt = T5_DM_ACK;
                  w_enter_ack = 1'b1;
               end else begin
                  w_state_nxt = T5_DM_WAIT;
                  w_cnt_nxt   = CNT_W'(WAIT - 1);
               end
            end
         end
         T5_DM_WAIT: begin
            if (!dwb_stb) begin
               w_state_nxt = T5_DM_IDLE;
            end else if (r_cnt == '0) begin
               w_state_nxt = T5_DM_ACK;
               w_enter_ack = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         T5_DM_ACK: begin
            w_state_nxt = T5_DM_IDLE;
         end
         default: begin
            w_state_nxt = T5_DM_IDLE;
         end
      endcase
   end

   // Request capture at accept; held for the rest of the transaction.
   always_ff @(posedge sys_clk) begin
      if (w_latch) begin
         r_wre <= dwb_wre;
         r_sel <= dwb_sel;
         r_adr <= dwb_adr;
         r_dto <= dwb_dto;
      end
   end

   // With zero wait states the commit edge is also the accept edge, so use the live bus there.
   always_comb begin
      w_cur_wre = r_wre;
      w_cur_sel = r_sel;
      w_cur_adr = r_adr;
      w_cur_dto = r_dto;
      if (r_state == T5_DM_IDLE) begin
         w_cur_wre = dwb_wre;
         w_cur_sel = dwb_sel;
         w_cur_adr = dwb_adr;
         w_cur_dto = dwb_dto;
      end
   end

   assign w_hit    = (w_cur_adr[XLEN-3:AW] == BASE[XLEN-1:AW+2]);
   assign w_commit = w_enter_ack && !sys_rst;
   assign w_we     = (w_commit && w_cur_wre && w_hit) ? w_cur_sel : '0;
   assign w_re     = w_commit && !w_cur_wre;

   t5_dmem_dram #(
      .XLEN (XLEN),
      .AW   (AW)
   ) u_dram (
      .i_clk     (sys_clk),
      .i_rst     (sys_rst),
      .i_we      (w_we),
      .i_addr    (w_cur_adr[AW-1:0]),
      .i_wdata   (w_cur_dto),
      .i_re      (w_re),
      .i_rd_zero (!w_hit),
      .o_rdata   (dwb_dti)
   );

   assign dwb_ack = r_ack;

endmodule : t5_dmem
